// File: rtl/req_capture.sv
// req_capture: edge-captured, maskable request pending bits presented to a 4:2 priority encoder under valid/ack.
// Optional macro REQ_CAPTURE_SYNC_EN adds a 2-flop synchroniser on each req_in bit.
`default_nettype none

module req_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  output logic [3:0] pend_out,
  output logic       irq_valid,
  input  logic       ack,
  input  logic [1:0] ack_idx,
  output logic [3:0] pending,
  output logic [3:0] ovf,
  input  logic       ovf_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] s;
  logic [3:0] s_d;
  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] ovf_set;

`ifdef REQ_CAPTURE_SYNC_EN
  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= req_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = req_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_d <= '0;
    else     s_d <= s;
  end

  // A clear only exists for an accepted handshake; a simultaneous rise overrides it.
  always_comb begin
    rise    = s & ~s_d;
    clr     = '0;
    if (state == REQ && ack) clr[ack_idx] = 1'b1;
    ovf_set = rise & pending & ~clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      ovf     <= ovf_clr ? ovf_set : (ovf | ovf_set);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_out  <= '0;
      irq_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((pending & mask) != 4'b0000) begin
            pend_out  <= pending & mask;
            irq_valid <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            pend_out  <= '0;
            irq_valid <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          pend_out  <= '0;
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_req_capture.sv
// tb_req_capture: directed scenarios plus random traffic checked against a behavioural model of req_capture.
`default_nettype none

module tb_req_capture;

`ifdef REQ_CAPTURE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic [3:0] pend_out;
  logic       irq_valid;
  logic       ack;
  logic [1:0] ack_idx;
  logic [3:0] pending;
  logic [3:0] ovf;
  logic       ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: hist[k] is req_in as sampled k+1 edges ago.
  logic [3:0] hist [0:2];
  logic [3:0] m_pend, m_ovf, m_snap;
  logic       m_valid, m_gap;

  req_capture dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .mask     (mask),
    .pend_out (pend_out),
    .irq_valid(irq_valid),
    .ack      (ack),
    .ack_idx  (ack_idx),
    .pending  (pending),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = 4'b0000;
    m_pend  = 4'b0000;
    m_ovf   = 4'b0000;
    m_snap  = 4'b0000;
    m_valid = 1'b0;
    m_gap   = 1'b0;
  endtask

  // One rising edge of the reference behaviour, using the inputs currently applied.
  task automatic model_edge();
    logic [3:0] cur, prev, rise, clrb, set_ovf;
    if (LAT == 1) begin
      cur  = req_in;
      prev = hist[0];
    end else begin
      cur  = hist[1];
      prev = hist[2];
    end
    rise    = cur & ~prev;
    clrb    = (m_valid && ack) ? (4'b0001 << ack_idx) : 4'b0000;
    set_ovf = rise & m_pend & ~clrb;
    if (m_valid) begin
      if (ack) begin
        m_valid = 1'b0;
        m_snap  = 4'b0000;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if ((m_pend & mask) != 4'b0000) begin
      m_valid = 1'b1;
      m_snap  = m_pend & mask;
    end
    m_pend  = (m_pend & ~clrb) | rise;
    m_ovf   = ovf_clr ? set_ovf : (m_ovf | set_ovf);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = req_in;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pending"},  {4'b0, pending},  {4'b0, m_pend});
    check({tag, ".ovf"},      {4'b0, ovf},      {4'b0, m_ovf});
    check({tag, ".pend_out"}, {4'b0, pend_out}, {4'b0, m_snap});
    check({tag, ".irq_valid"},{7'b0, irq_valid},{7'b0, m_valid});
  endtask

  // Called at a negedge: apply inputs, take one rising edge, compare, return at next negedge.
  task automatic step(input logic [3:0] r, input logic [3:0] m, input logic a,
                      input logic [1:0] ai, input logic oc, input string tag);
    req_in  = r;
    mask    = m;
    ack     = a;
    ack_idx = ai;
    ovf_clr = oc;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n, input logic [3:0] r, input logic [3:0] m);
    for (int i = 0; i < n; i++) step(r, m, 1'b0, 2'd0, 1'b0, "idle");
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    req_in  = 4'b0000;
    ack     = 1'b0;
    ovf_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_in = '0; mask = 4'hF; ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Single request: capture latency then presentation one edge later.
    idle_steps(LAT, 4'b0001, 4'b1111);
    check("s1.pending", {4'b0, pending}, 8'h01);
    check("s1.valid_early", {7'b0, irq_valid}, 8'h00);
    idle_steps(1, 4'b0001, 4'b1111);
    check("s1.valid", {7'b0, irq_valid}, 8'h01);
    check("s1.pend_out", {4'b0, pend_out}, 8'h01);
    step(4'b0001, 4'hF, 1'b1, 2'd0, 1'b0, "s1.ack");
    idle_steps(LAT + 2, 4'b0000, 4'hF);

    // Snapshot frozen while new edges accumulate in pending.
    idle_steps(LAT + 1, 4'b0100, 4'hF);
    check("s2.pend_out0", {4'b0, pend_out}, 8'h04);
    idle_steps(LAT + 1, 4'b1100, 4'hF);
    check("s2.pend_out_held", {4'b0, pend_out}, 8'h04);
    check("s2.pending", {4'b0, pending}, 8'h0C);
    step(4'b1100, 4'hF, 1'b1, 2'd2, 1'b0, "s2.ack");
    check("s2.valid_ack", {7'b0, irq_valid}, 8'h00);
    idle_steps(1, 4'b1100, 4'hF);
    check("s2.valid_gap", {7'b0, irq_valid}, 8'h00);
    idle_steps(1, 4'b1100, 4'hF);
    check("s2.pend_out1", {4'b0, pend_out}, 8'h08);
    step(4'b1100, 4'hF, 1'b1, 2'd3, 1'b0, "s2.ack3");
    idle_steps(LAT + 2, 4'b0000, 4'hF);

    // Masked capture, presented once unmasked.
    idle_steps(LAT + 2, 4'b0001, 4'b1110);
    check("s3.pending", {4'b0, pending}, 8'h01);
    check("s3.valid_masked", {7'b0, irq_valid}, 8'h00);
    idle_steps(1, 4'b0001, 4'b1111);
    check("s3.pend_out", {4'b0, pend_out}, 8'h01);
    step(4'b0001, 4'hF, 1'b1, 2'd0, 1'b0, "s3.ack");
    idle_steps(LAT + 2, 4'b0000, 4'hF);

    // Overflow on a second rise of line 3, then clear.
    idle_steps(LAT + 1, 4'b1000, 4'hF);
    idle_steps(3, 4'b0000, 4'hF);
    idle_steps(LAT + 1, 4'b1000, 4'hF);
    check("s4.ovf", {4'b0, ovf}, 8'h08);
    check("s4.pending", {4'b0, pending}, 8'h08);
    step(4'b1000, 4'hF, 1'b0, 2'd0, 1'b1, "s4.clr");
    check("s4.ovf_clr", {4'b0, ovf}, 8'h00);
    step(4'b1000, 4'hF, 1'b1, 2'd3, 1'b0, "s4.ack");
    idle_steps(LAT + 2, 4'b0000, 4'hF);

    // Rise coinciding with the ack that clears the same line.
    idle_steps(LAT + 1, 4'b0010, 4'hF);
    idle_steps(3, 4'b0000, 4'hF);
    idle_steps(LAT - 1, 4'b0010, 4'hF);
    step(4'b0010, 4'hF, 1'b1, 2'd1, 1'b0, "s5.ack");
    check("s5.pending", {4'b0, pending}, 8'h02);
    check("s5.ovf", {4'b0, ovf}, 8'h00);
    idle_steps(2, 4'b0010, 4'hF);
    check("s5.represent", {4'b0, pend_out}, 8'h02);

    // Asynchronous reset while a snapshot is held, then a stray ack in IDLE.
    async_reset();
    step(4'b0000, 4'hF, 1'b1, 2'd1, 1'b0, "s6.idle_ack");
    check("s6.pending", {4'b0, pending}, 8'h00);
    check("s6.valid", {7'b0, irq_valid}, 8'h00);

    // Random traffic; requests change only every other cycle.
    begin
      logic [3:0] r, m;
      r = 4'b0000;
      m = 4'hF;
      for (int i = 0; i < 600; i++) begin
        if (i % 2 == 0) r = r ^ 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) m = 4'($urandom_range(0, 15));
        step(r, m, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 15) == 0), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
